cpu_multicycle: RTL
===================

Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor of the single-cycle sequential core. Executes an RV-style integer subset over a state machine (FETCH/DECODE/EXECUTE/MEM/WB).
- Has req/ready handshakes to external instruction and data memories, so memory can have wait states.
- Register file, ALU, immediate generation and PC logic are internal.
- Top-level CPU for the next-generation test benches.

Parameters:
- XLEN, 64, datapath and register width (32 or 64).
- RESET_PC, 0, PC value loaded on reset.
- NUM_REGS, 32, architectural registers; x0 hardwired to zero.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address (current PC).
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  byte address (rs1 + imm).
- dmem_wdata  out  XLEN  store data (rs2).
- dmem_ready  in  1  access complete; rdata valid for loads.
- dmem_rdata  in  XLEN  load data.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  core stopped (ebreak or illegal opcode).
- trap  out  1  1 if the halt was caused by an illegal instruction.
- pc_out  out  XLEN  current PC, for debug.

Behaviour:
- Reset (reset=0, takes effect immediately):
  - state=FETCH, PC=RESET_PC, all registers 0, IR=0.
  - imem_req, dmem_req, dmem_we, retire, halted and trap all 0.
  - Reset asserted mid-handshake drops req asynchronously.
  - The first fetch starts on the first rising edge after release.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - Req is held until a rising edge samples imem_ready=1; IR<=imem_rdata on that edge, then go to DECODE.
  - With ready tied high, FETCH takes 1 cycle.
- DECODE (1 cycle): read rs1/rs2 into A/B, generate the sign-extended immediate (I/S/B/J formats).
- EXECUTE (1 cycle): ALU computes into ALUOut. Then:
  - R/I-ALU and jal go to WB.
  - ld and sd go to MEM.
  - beq/bne: PC<=PC+immB if the condition holds, else PC+4; retire=1; go to FETCH.
- MEM:
  - dmem_req=1 with address/wdata/we stable until an edge samples dmem_ready=1.
  - Load: MDR<=dmem_rdata, go to WB.
  - Store: PC+=4, retire, go to FETCH.
- WB (1 cycle):
  - rd<=ALUOut, MDR, or PC+4 for jal.
  - PC<=PC+4, or PC+immJ for jal.
  - retire=1, go to FETCH.
- Writes to x0 are discarded.
- Zero-wait latencies: ALU/jal 4 cycles, load 5, store 4, branch 3.
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt, sll, srl, sra.
  - I-type: addi, andi, ori, xori.
  - Memory: load/store full-XLEN words (funct3 011 for XLEN=64, 010 for XLEN=32).
  - Control: beq, bne, jal, ebreak.
- Arithmetic is modulo 2^XLEN. Shift amount is rs2/imm[log2(XLEN)-1:0]. slt is signed.
- ebreak reaching EXECUTE: state=HALT, halted=1, retire=1, PC unchanged.
- Unknown opcode/funct: state=HALT, halted=1, trap=1, no retire, no register or memory write.
- HALT is left only by reset.
- PC is not alignment-checked; it always increments by 4 and wraps modulo 2^XLEN.

Optional Feature:
- Macro: CPU_MULTICYCLE_PERF_EN.
- Defined: adds outputs cycle_count[63:0] and instret_count[63:0].
  - Both reset to 0.
  - cycle_count increments every non-HALT cycle.
  - instret_count increments on each retire pulse.
  - Both wrap at 2^64.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 with ready tied high -> x3=12, retire pulses at cycles 4, 8, 12, pc_out=12.
- imem_ready held low for 3 cycles on the first fetch -> imem_req/addr stay stable for 4 cycles, IR loaded only on the ready edge, retire delayed by 3 cycles.
- sd x3,8(x0) then ld x4,8(x0) with a 2-cycle dmem wait each -> store has dmem_we=1, addr=8, wdata=12; load gives x4=12; store total 6 cycles, load 7.
- x1=5, x2=5: beq x1,x2,+8 -> PC skips one instruction; bne x1,x2,+8 -> PC+4; each branch 3 cycles.
- addi x0,x0,9 then jal x5,-4 at PC=0x20 -> x0 reads 0, x5=0x24, PC=0x1C.
- Opcode 0x7F -> halted=1, trap=1, no retire. Then reset pulsed low mid-FETCH -> PC=RESET_PC, halted=0, imem_req=0 immediately.

Source files
------------

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV-style integer core (FETCH/DECODE/EXECUTE/MEM/WB) with ready-handshaked memories.
// Define CPU_MULTICYCLE_PERF_EN to add the cycle_count/instret_count performance counters.
module cpu_multicycle #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            retire,
   output logic            halted,
   output logic            trap,
   output logic [XLEN-1:0] pc_out
`ifdef CPU_MULTICYCLE_PERF_EN
   ,
   output logic [63:0]     cycle_count,
   output logic [63:0]     instret_count
`endif
);

   localparam int              SHW    = $clog2(XLEN);
   localparam int              RIW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [2:0]      LS_F3  = (XLEN == 64) ? 3'b011 : 3'b010;
   localparam logic [XLEN-1:0] PC_INC = XLEN'(4);
   localparam logic [6:0]      OP_R   = 7'b0110011;
   localparam logic [6:0]      OP_I   = 7'b0010011;
   localparam logic [6:0]      OP_LD  = 7'b0000011;
   localparam logic [6:0]      OP_ST  = 7'b0100011;
   localparam logic [6:0]      OP_BR  = 7'b1100011;
   localparam logic [6:0]      OP_JAL = 7'b1101111;
   localparam logic [31:0]     EBREAK = 32'h0010_0073;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t                 r_state, w_next;
   logic [XLEN-1:0]        r_pc, r_a, r_b, r_imm, r_aluout, r_mdr;
   logic [31:0]            r_ir;
   logic                   r_trap;
   logic [XLEN-1:0]        r_regs [NUM_REGS];

   logic [6:0]             w_opcode, w_f7;
   logic [4:0]             w_rd, w_rs1, w_rs2;
   logic [2:0]             w_f3;
   logic [XLEN-1:0]        w_rs1_val, w_rs2_val, w_imm, w_op2, w_alu, w_wb_data;
   logic signed [XLEN-1:0] w_a_s, w_op2_s;
   logic [SHW-1:0]         w_shamt;
   logic                   w_legal, w_is_ebreak, w_is_store, w_br_taken, w_rd_ok;

   assign w_opcode    = r_ir[6:0];
   assign w_rd        = r_ir[11:7];
   assign w_f3        = r_ir[14:12];
   assign w_rs1       = r_ir[19:15];
   assign w_rs2       = r_ir[24:20];
   assign w_f7        = r_ir[31:25];
   assign w_is_ebreak = (r_ir == EBREAK);
   assign w_is_store  = (w_opcode == OP_ST);
   assign w_br_taken  = (r_a == r_b) ^ w_f3[0];
   assign w_rd_ok     = (w_rd != 5'd0) && (int'(w_rd) < NUM_REGS);

   // Register file read; indices beyond NUM_REGS and x0 read as zero
   always_comb begin
      w_rs1_val = '0;
      w_rs2_val = '0;
      if (w_rs1 != 5'd0 && int'(w_rs1) < NUM_REGS) w_rs1_val = r_regs[w_rs1[RIW-1:0]];
      if (w_rs2 != 5'd0 && int'(w_rs2) < NUM_REGS) w_rs2_val = r_regs[w_rs2[RIW-1:0]];
   end

   always_comb begin
      case (w_opcode)
         OP_ST:   w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
         OP_BR:   w_imm = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
         OP_JAL:  w_imm = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
         default: w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
      endcase
   end

   always_comb begin
      w_legal = 1'b0;
      case (w_opcode)
         OP_R:         w_legal = ((w_f7 == 7'b0000000) && (w_f3 != 3'b011)) ||
                                 ((w_f7 == 7'b0100000) && (w_f3 == 3'b000 || w_f3 == 3'b101));
         OP_I:         w_legal = w_f3 inside {3'b000, 3'b100, 3'b110, 3'b111};
         OP_LD, OP_ST: w_legal = (w_f3 == LS_F3);
         OP_BR:        w_legal = (w_f3[2:1] == 2'b00);
         OP_JAL:       w_legal = 1'b1;
         default:      w_legal = w_is_ebreak;
      endcase
   end

   // ALU: loads/stores fall through to the default add for address generation
   always_comb begin
      w_op2   = (w_opcode == OP_R) ? r_b : r_imm;
      w_a_s   = $signed(r_a);
      w_op2_s = $signed(w_op2);
      w_shamt = w_op2[SHW-1:0];
      w_alu   = r_a + w_op2;
      if (w_opcode == OP_R || w_opcode == OP_I) begin
         case (w_f3)
            3'b000:  w_alu = (w_opcode == OP_R && w_f7[5]) ? (r_a - w_op2) : (r_a + w_op2);
            3'b111:  w_alu = r_a & w_op2;
            3'b110:  w_alu = r_a | w_op2;
            3'b100:  w_alu = r_a ^ w_op2;
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, (w_a_s < w_op2_s)};
            3'b001:  w_alu = r_a << w_shamt;
            3'b101:  w_alu = w_f7[5] ? $unsigned(w_a_s >>> w_shamt) : (r_a >> w_shamt);
            default: w_alu = r_a + w_op2;
         endcase
      end
   end

   always_comb begin
      if (w_opcode == OP_JAL)     w_wb_data = r_pc + PC_INC;
      else if (w_opcode == OP_LD) w_wb_data = r_mdr;
      else                        w_wb_data = r_aluout;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // imem_req is gated by reset so an asserted reset drops it without waiting for a clock
   always_comb begin
      w_next   = r_state;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
      case (r_state)
         S_FETCH: begin
            imem_req = reset;
            if (imem_ready) w_next = S_DECODE;
         end
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            if (!w_legal) begin
               w_next = S_HALT;
            end else if (w_is_ebreak) begin
               retire = 1'b1;
               w_next = S_HALT;
            end else if (w_opcode == OP_BR) begin
               retire = 1'b1;
               w_next = S_FETCH;
            end else if (w_opcode == OP_LD || w_is_store) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = w_is_store;
            if (dmem_ready) begin
               retire = w_is_store;
               w_next = w_is_store ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            retire = 1'b1;
            w_next = S_FETCH;
         end
         default: w_next = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_imm    <= '0;
         r_aluout <= '0;
         r_mdr    <= '0;
         r_trap   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         case (r_state)
            S_FETCH: if (imem_ready) r_ir <= imem_rdata;
            S_DECODE: begin
               r_a   <= w_rs1_val;
               r_b   <= w_rs2_val;
               r_imm <= w_imm;
            end
            S_EXEC: begin
               r_aluout <= w_alu;
               if (!w_legal) r_trap <= 1'b1;
               else if (w_opcode == OP_BR) r_pc <= w_br_taken ? (r_pc + r_imm) : (r_pc + PC_INC);
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (w_is_store) r_pc <= r_pc + PC_INC;
                  else            r_mdr <= dmem_rdata;
               end
            end
            S_WB: begin
               if (w_rd_ok) r_regs[w_rd[RIW-1:0]] <= w_wb_data;
               r_pc <= (w_opcode == OP_JAL) ? (r_pc + r_imm) : (r_pc + PC_INC);
            end
            default: ;
         endcase
      end
   end

   assign imem_addr  = r_pc;
   assign dmem_addr  = r_aluout;
   assign dmem_wdata = r_b;
   assign halted     = (r_state == S_HALT);
   assign trap       = r_trap;
   assign pc_out     = r_pc;

`ifdef CPU_MULTICYCLE_PERF_EN
   logic [63:0] r_cycle_cnt, r_instret_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 64'd1;
         if (retire)            r_instret_cnt <= r_instret_cnt + 64'd1;
      end
   end

   assign cycle_count   = r_cycle_cnt;
   assign instret_count = r_instret_cnt;
`endif

endmodule
